// File: rtl/ram1_ctrl_pkg.sv
// Shared definitions for the Ram1 controller: FSM states, UART addresses and strobe idle level.
package ram1_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_SETUP,
      S_RD_LATCH,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_U_RD,
      S_U_WR,
      S_DONE
   } state_t;

   localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
   localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
   localparam logic        STROBE_IDLE    = 1'b1;

   // States in which the controller owns the shared data bus.
   function automatic logic busDriven(state_t s);
      return (s == S_WR_SETUP) || (s == S_WR_PULSE) || (s == S_WR_HOLD) || (s == S_U_WR);
   endfunction

endpackage

// File: rtl/ram1_ctrl_uart.sv
// UART strobe timing and status word for the Ram1 controller; only exists when RAM1_UART_EN is defined.
`ifdef RAM1_UART_EN
module uart_port_if (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rdActive,
   input  logic        i_wrActive,
   input  logic        i_dready,
   input  logic        i_tbre,
   input  logic        i_tsre,
   output logic        o_rdn,
   output logic        o_wrn,
   output logic        o_rdLast,
   output logic [15:0] o_status
);

   logic r_rdCnt;

   // The read strobe spans two cycles; the second one is where the data gets latched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdCnt <= 1'b0;
      end else if (i_rdActive) begin
         r_rdCnt <= ~r_rdCnt;
      end else begin
         r_rdCnt <= 1'b0;
      end
   end

   assign o_rdn    = ~i_rdActive;
   assign o_wrn    = ~i_wrActive;
   assign o_rdLast = i_rdActive & r_rdCnt;
   assign o_status = {14'b0, i_dready, i_tbre & i_tsre};

endmodule
`endif

// File: rtl/ram1_ctrl.sv
// Ram1 SRAM access controller behind the MEM stage; optional UART port on the shared bus (RAM1_UART_EN).
module ram1_ctrl
   import ram1_ctrl_pkg::*;
#(
   parameter int ADDR_W       = 18,
   parameter int WR_PULSE_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_en_n,
   input  logic              req_wr,
   input  logic [15:0]       addr,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram1_addr,
   inout  wire  [15:0]       ram1_data,
   output logic              ram1_en,
   output logic              ram1_oe,
   output logic              ram1_we,
   output logic              uart_rdn,
   output logic              uart_wrn,
   input  logic              uart_dready,
   input  logic              uart_tbre,
   input  logic              uart_tsre
);

   localparam logic [2:0] PULSE_LAST = 3'(WR_PULSE_CYC - 1);

   state_t      r_state;
   state_t      w_nextState;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_rdata;
   logic [2:0]  r_pulseCnt;
   logic        w_uRdLast;
   logic        w_reqTaken;

   assign w_reqTaken = (r_state == S_IDLE) && !req_en_n;

`ifdef RAM1_UART_EN
   logic [15:0] w_uStatus;

   uart_port_if u_uart (
      .clk        (clk),
      .rst        (rst),
      .i_rdActive (r_state == S_U_RD),
      .i_wrActive (r_state == S_U_WR),
      .i_dready   (uart_dready),
      .i_tbre     (uart_tbre),
      .i_tsre     (uart_tsre),
      .o_rdn      (uart_rdn),
      .o_wrn      (uart_wrn),
      .o_rdLast   (w_uRdLast),
      .o_status   (w_uStatus)
   );
`else
   logic w_unused;

   assign uart_rdn  = STROBE_IDLE;
   assign uart_wrn  = STROBE_IDLE;
   assign w_uRdLast = 1'b1;
   assign w_unused  = uart_dready ^ uart_tbre ^ uart_tsre;
`endif

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (!req_en_n) begin
`ifdef RAM1_UART_EN
               if (addr == UART_STAT_ADDR) begin
                  w_nextState = S_DONE;
               end else if (addr == UART_DATA_ADDR) begin
                  w_nextState = req_wr ? S_U_WR : S_U_RD;
               end else
`endif
               begin
                  w_nextState = req_wr ? S_WR_SETUP : S_RD_SETUP;
               end
            end
         end
         S_RD_SETUP: w_nextState = S_RD_LATCH;
         S_RD_LATCH: w_nextState = S_DONE;
         S_WR_SETUP: w_nextState = S_WR_PULSE;
         S_WR_PULSE: if (r_pulseCnt == PULSE_LAST) w_nextState = S_WR_HOLD;
         S_WR_HOLD:  w_nextState = S_DONE;
         S_U_RD:     if (w_uRdLast) w_nextState = S_DONE;
         S_U_WR:     w_nextState = S_DONE;
         S_DONE:     w_nextState = S_IDLE;
         default:    w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= 16'h0000;
         r_wdata    <= 16'h0000;
         r_pulseCnt <= 3'd0;
      end else begin
         r_state <= w_nextState;
         if (w_reqTaken) begin
            r_addr  <= addr;
            r_wdata <= wdata;
         end
         r_pulseCnt <= (r_state == S_WR_PULSE) ? r_pulseCnt + 3'd1 : 3'd0;
      end
   end

   // Load data is held until the next load, so writes and status writes leave it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= 16'h0000;
      end else if (r_state == S_RD_LATCH) begin
         r_rdata <= ram1_data;
`ifdef RAM1_UART_EN
      end else if ((r_state == S_U_RD) && w_uRdLast) begin
         r_rdata <= {8'h00, ram1_data[7:0]};
      end else if (w_reqTaken && !req_wr && (addr == UART_STAT_ADDR)) begin
         r_rdata <= w_uStatus;
`endif
      end
   end

   assign ram1_en   = !((r_state == S_RD_SETUP) || (r_state == S_RD_LATCH) ||
                        (r_state == S_WR_SETUP) || (r_state == S_WR_PULSE) ||
                        (r_state == S_WR_HOLD));
   assign ram1_oe   = !((r_state == S_RD_SETUP) || (r_state == S_RD_LATCH));
   assign ram1_we   = (r_state != S_WR_PULSE);
   assign ram1_addr = ADDR_W'(r_addr);
   assign ram1_data = busDriven(r_state) ? r_wdata : 16'hzzzz;
   assign rdata     = r_rdata;
   assign done      = (r_state == S_DONE);
   assign busy      = ((r_state != S_IDLE) && (r_state != S_DONE)) || w_reqTaken;

endmodule

// File: tb/tb_ram1_ctrl.sv
// Scoreboard bench for ram1_ctrl: directed accesses push expectations, a negedge monitor checks each done pulse.
module tb_ram1_ctrl;

   localparam int WP = 3;

   typedef struct {
      logic [15:0] rdata;
      int          busyCyc;
      logic [17:0] addr;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_en_n;
   logic        req_wr;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        busy;
   logic        done;
   logic [17:0] ram1_addr;
   wire  [15:0] ram1_data;
   logic        ram1_en;
   logic        ram1_oe;
   logic        ram1_we;
   logic        uart_rdn;
   logic        uart_wrn;
   logic        uart_dready;
   logic        uart_tbre;
   logic        uart_tsre;

   exp_t        sbQ[$];
   logic [15:0] mem [256];
   logic [15:0] holdRd;
   int          nAssert;
   int          nFail;

   ram1_ctrl #(.ADDR_W(18), .WR_PULSE_CYC(WP)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_en_n    (req_en_n),
      .req_wr      (req_wr),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .busy        (busy),
      .done        (done),
      .ram1_addr   (ram1_addr),
      .ram1_data   (ram1_data),
      .ram1_en     (ram1_en),
      .ram1_oe     (ram1_oe),
      .ram1_we     (ram1_we),
      .uart_rdn    (uart_rdn),
      .uart_wrn    (uart_wrn),
      .uart_dready (uart_dready),
      .uart_tbre   (uart_tbre),
      .uart_tsre   (uart_tsre)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus environment: SRAM drives on en&oe, UART on rdn, otherwise a known idle pattern stands in for hi-Z.
   assign ram1_data = (!ram1_en && !ram1_oe)           ? mem[ram1_addr[7:0]] :
                      (!uart_rdn)                      ? 16'hAB41 :
                      (ram1_en && uart_rdn && uart_wrn) ? 16'hC3C3 : 16'hzzzz;

   always @(posedge ram1_we) begin
      if (!ram1_en) mem[ram1_addr[7:0]] = ram1_data;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: protocol invariants every cycle, scoreboard pop on every done pulse.
   int  busyCnt, weLowCnt, rdnLowCnt, wrnLowCnt;
   logic prevDone;
   always @(negedge clk) begin
      if (rst) begin
         busyCnt = 0; weLowCnt = 0; rdnLowCnt = 0; wrnLowCnt = 0; prevDone = 1'b0;
      end else begin
         checkOutput("oe_we_not_both_low", {31'b0, ram1_oe | ram1_we}, 1);
         checkOutput("en_high_in_uart", {31'b0, (uart_rdn & uart_wrn) | ram1_en}, 1);
         if (!ram1_we) weLowCnt++;
         else if (weLowCnt != 0) begin checkOutput("we_low_cycles", weLowCnt, WP); weLowCnt = 0; end
         if (!uart_rdn) rdnLowCnt++;
         else if (rdnLowCnt != 0) begin checkOutput("rdn_low_cycles", rdnLowCnt, 2); rdnLowCnt = 0; end
         if (!uart_wrn) wrnLowCnt++;
         else if (wrnLowCnt != 0) begin checkOutput("wrn_low_cycles", wrnLowCnt, 1); wrnLowCnt = 0; end
         if (done) begin
            checkOutput("done_single_pulse", {31'b0, prevDone}, 0);
            checkOutput("busy_low_in_done", {31'b0, busy}, 0);
            checkOutput("bus_released_in_done", {16'b0, ram1_data}, 32'h0000C3C3);
            if (sbQ.size() == 0) begin
               checkOutput("unexpected_done", 0, 1);
            end else begin
               exp_t e;
               e = sbQ.pop_front();
               checkOutput("rdata", {16'b0, rdata}, {16'b0, e.rdata});
               checkOutput("busy_cycles", busyCnt, e.busyCyc);
               checkOutput("ram1_addr", {14'b0, ram1_addr}, {14'b0, e.addr});
            end
            busyCnt = 0;
         end else if (busy) begin
            busyCnt++;
         end
         prevDone = done;
      end
   end

   task automatic applyStimulus(input logic wr, input logic [15:0] a, input logic [15:0] d,
                                input int expBusy, input bit keepReq);
      exp_t e;
      bit   got;
      e.rdata   = holdRd;
      e.busyCyc = expBusy;
      e.addr    = {2'b00, a};
      sbQ.push_back(e);
      req_wr   = wr;
      addr     = a;
      wdata    = d;
      req_en_n = 1'b0;
      got      = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #2;
         if (done) begin got = 1'b1; break; end
      end
      checkOutput("access_completes", {31'b0, got}, 1);
      if (!keepReq) req_en_n = 1'b1;
   endtask

   task automatic doRead(input logic [15:0] a, input logic [15:0] expRd, input int expBusy, input bit keepReq);
      holdRd = expRd;
      applyStimulus(1'b0, a, 16'h0000, expBusy, keepReq);
   endtask

   task automatic doWrite(input logic [15:0] a, input logic [15:0] d, input int expBusy, input bit keepReq);
      applyStimulus(1'b1, a, d, expBusy, keepReq);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit sawPulse;
      nAssert = 0; nFail = 0; holdRd = 16'h0000;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      rst = 1'b1; req_en_n = 1'b1; req_wr = 1'b0; addr = 16'h0000; wdata = 16'h0000;
      uart_dready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0;

      repeat (2) @(posedge clk); #2;
      checkOutput("rst_en", {31'b0, ram1_en}, 1);
      checkOutput("rst_oe", {31'b0, ram1_oe}, 1);
      checkOutput("rst_we", {31'b0, ram1_we}, 1);
      checkOutput("rst_uart_strobes", {30'b0, uart_rdn, uart_wrn}, 3);
      checkOutput("rst_rdata", {16'b0, rdata}, 0);
      checkOutput("rst_done_busy", {30'b0, done, busy}, 0);
      checkOutput("rst_addr", {14'b0, ram1_addr}, 0);
      checkOutput("rst_bus_z", {16'b0, ram1_data}, 32'h0000C3C3);
      rst = 1'b0;
      @(posedge clk); #2;

      doWrite(16'h0040, 16'h1234, 3 + WP, 1'b0);
      doRead (16'h0040, 16'h1234, 3, 1'b0);

      doWrite(16'h0041, 16'hA5A5, 3 + WP, 1'b1);
      doWrite(16'h0042, 16'h5A5A, 3 + WP, 1'b1);
      doWrite(16'h8043, 16'hFFFF, 3 + WP, 1'b0);
      doRead (16'h0041, 16'hA5A5, 3, 1'b1);
      doRead (16'h0042, 16'h5A5A, 3, 1'b1);
      doRead (16'h8043, 16'hFFFF, 3, 1'b0);
      @(posedge clk); #2;

      // Reset in the middle of the write pulse.
      req_wr = 1'b1; addr = 16'h0050; wdata = 16'hBEEF; req_en_n = 1'b0;
      @(posedge clk); #2;
      req_en_n = 1'b1;
      sawPulse = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!ram1_we) begin sawPulse = 1'b1; break; end
      end
      checkOutput("mid_write_pulse_seen", {31'b0, sawPulse}, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("midrst_we", {31'b0, ram1_we}, 1);
      checkOutput("midrst_en", {31'b0, ram1_en}, 1);
      checkOutput("midrst_bus_z", {16'b0, ram1_data}, 32'h0000C3C3);
      checkOutput("midrst_rdata", {16'b0, rdata}, 0);
      checkOutput("midrst_idle", {30'b0, busy, done}, 0);
      sbQ.delete();
      holdRd = 16'h0000;
      repeat (2) @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;

      doRead(16'h0040, 16'h1234, 3, 1'b0);

`ifdef RAM1_UART_EN
      uart_dready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
      doRead(16'hBF01, 16'h0003, 1, 1'b0);
      uart_dready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
      doRead(16'hBF01, 16'h0002, 1, 1'b0);
      uart_dready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1;
      doRead(16'hBF01, 16'h0001, 1, 1'b0);
      doWrite(16'hBF01, 16'h5555, 1, 1'b0);
      doRead(16'hBF00, 16'h0041, 3, 1'b0);
      doWrite(16'hBF00, 16'h0061, 2, 1'b0);
      doRead(16'h0041, 16'hA5A5, 3, 1'b0);
`endif

      repeat (3) @(posedge clk); #2;
      checkOutput("scoreboard_drained", sbQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
